// File: rtl/sa_wresp_merge.sv
// Write-response merger: tracks issued AWs, folds split sub-responses into one
// prioritised BRESP and routes the merged response to the originating master.
module sa_wresp_merge #(
  parameter int MST_AMT         = 4,
  parameter int OUTSTANDING_AMT = 8,
  parameter int MST_ID_W        = $clog2(MST_AMT),
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
  parameter int TRANS_WR_RESP_W = 2,
  parameter int SPLIT_W         = 3
) (
  input  logic                                ACLK_i,
  input  logic                                ARESET_i,
  input  logic [TRANS_SLV_ID_W-1:0]           AW_AxID_i,
  input  logic [SPLIT_W-1:0]                  AW_split_num_i,
  input  logic                                AW_shift_en_i,
  output logic                                AW_stall_o,
  input  logic [TRANS_SLV_ID_W-1:0]           s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]          s_BRESP_i,
  input  logic                                s_BVALID_i,
  output logic                                s_BREADY_o,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]   dsp_BID_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]  dsp_BRESP_o,
  output logic [MST_AMT-1:0]                  dsp_BVALID_o,
  input  logic [MST_AMT-1:0]                  dsp_BREADY_i,
  output logic                                id_mismatch_o
);

  localparam int PTR_W = $clog2(OUTSTANDING_AMT);
  localparam int ENT_W = SPLIT_W + TRANS_SLV_ID_W;
  localparam int RK_W  = TRANS_WR_RESP_W + 1;

  typedef enum logic {EMPTY, FULL} out_state_e;

  logic [ENT_W-1:0]           fifo_mem [OUTSTANDING_AMT];
  logic [PTR_W:0]             wr_ptr, rd_ptr;
  logic                       fifo_full, fifo_empty;
  logic                       push, pop;
  logic [ENT_W-1:0]           head;
  logic [SPLIT_W-1:0]         head_split;
  logic [TRANS_SLV_ID_W-1:0]  head_id;

  logic [SPLIT_W-1:0]         sub_cnt;
  logic [TRANS_WR_RESP_W-1:0] acc_resp;
  logic                       acc_vld;
  logic [TRANS_WR_RESP_W-1:0] merged_resp;
  logic                       handshake, final_hs;

  out_state_e                 out_state, out_state_nxt;
  logic [MST_ID_W-1:0]        out_mst;
  logic [TRANS_MST_ID_W-1:0]  out_id;
  logic [TRANS_WR_RESP_W-1:0] out_resp;
  logic                       drain;
  logic                       mismatch_q;

  // Ordering used for merging: DECERR > SLVERR > OKAY > EXOKAY.
  function automatic logic [RK_W-1:0] resp_rank(input logic [TRANS_WR_RESP_W-1:0] r);
    if (r == TRANS_WR_RESP_W'(0))      return RK_W'(1);
    else if (r == TRANS_WR_RESP_W'(1)) return RK_W'(0);
    else                               return {1'b0, r} + RK_W'(1);
  endfunction

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign head_split = head[ENT_W-1 -: SPLIT_W];
  assign head_id    = head[TRANS_SLV_ID_W-1:0];

  assign drain      = (out_state == FULL) && dsp_BREADY_i[out_mst];
  assign s_BREADY_o = !ARESET_i && !fifo_empty &&
                      ((sub_cnt < head_split) || (out_state == EMPTY) || drain);
  assign handshake  = s_BVALID_i && s_BREADY_o;
  assign final_hs   = handshake && (sub_cnt == head_split);
  assign pop        = final_hs;
  // A push at full is accepted only when the head is retiring in the same cycle.
  assign push       = AW_shift_en_i && (!fifo_full || pop);
  assign AW_stall_o = fifo_full && !ARESET_i;

  always_comb begin
    merged_resp = acc_resp;
    if (!acc_vld || (resp_rank(s_BRESP_i) > resp_rank(acc_resp))) merged_resp = s_BRESP_i;
  end

  always_ff @(posedge ACLK_i) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {AW_split_num_i, AW_AxID_i};
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      sub_cnt  <= '0;
      acc_resp <= '0;
      acc_vld  <= 1'b0;
    end else if (final_hs) begin
      sub_cnt  <= '0;
      acc_resp <= '0;
      acc_vld  <= 1'b0;
    end else if (handshake) begin
      sub_cnt  <= sub_cnt + 1'b1;
      acc_resp <= merged_resp;
      acc_vld  <= 1'b1;
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i)                              mismatch_q <= 1'b0;
    else if (handshake && (s_BID_i != head_id)) mismatch_q <= 1'b1;
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) out_state <= EMPTY;
    else          out_state <= out_state_nxt;
  end

  always_comb begin
    out_state_nxt = out_state;
    case (out_state)
      EMPTY:   if (final_hs) out_state_nxt = FULL;
      FULL:    if (final_hs) out_state_nxt = FULL;
               else if (drain) out_state_nxt = EMPTY;
      default: out_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      out_mst  <= '0;
      out_id   <= '0;
      out_resp <= '0;
    end else if (final_hs) begin
      out_mst  <= s_BID_i[TRANS_SLV_ID_W-1 -: MST_ID_W];
      out_id   <= s_BID_i[TRANS_MST_ID_W-1:0];
      out_resp <= merged_resp;
    end
  end

  always_comb begin
    dsp_BVALID_o  = '0;
    dsp_BID_o     = '0;
    dsp_BRESP_o   = '0;
    id_mismatch_o = 1'b0;
    if (!ARESET_i) begin
      if (out_state == FULL) dsp_BVALID_o[out_mst] = 1'b1;
      dsp_BID_o     = {MST_AMT{out_id}};
      dsp_BRESP_o   = {MST_AMT{out_resp}};
      id_mismatch_o = mismatch_q;
    end
  end

endmodule

// File: tb/tb_sa_wresp_merge.sv
// Bench for sa_wresp_merge: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a queue-based model.
module tb_sa_wresp_merge;

  localparam int MST_AMT = 4;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  aw_id;
  logic [2:0]  aw_split;
  logic        aw_shift;
  logic        aw_stall;
  logic [6:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [19:0] dsp_bid;
  logic [7:0]  dsp_bresp;
  logic [3:0]  dsp_bvalid;
  logic [3:0]  dsp_bready;
  logic        id_mismatch;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sa_wresp_merge dut (
    .ACLK_i        (clk),
    .ARESET_i      (rst),
    .AW_AxID_i     (aw_id),
    .AW_split_num_i(aw_split),
    .AW_shift_en_i (aw_shift),
    .AW_stall_o    (aw_stall),
    .s_BID_i       (s_bid),
    .s_BRESP_i     (s_bresp),
    .s_BVALID_i    (s_bvalid),
    .s_BREADY_o    (s_bready),
    .dsp_BID_o     (dsp_bid),
    .dsp_BRESP_o   (dsp_bresp),
    .dsp_BVALID_o  (dsp_bvalid),
    .dsp_BREADY_i  (dsp_bready),
    .id_mismatch_o (id_mismatch)
  );

  typedef struct { int split; int id; } ent_t;
  ent_t mq[$];
  int   m_sub = 0;
  int   m_best = -1;
  bit   m_full = 0;
  int   m_mst = 0, m_id = 0, m_resp = 0;
  bit   m_mism = 0;
  int   rank_of[4] = '{1, 0, 2, 3};

  function automatic int merge_resp(int best, int code);
    if (best < 0) return code;
    return (rank_of[code] > rank_of[best]) ? code : best;
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs predicted from model state, then state advanced
  // using the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    logic [19:0] e_bid;
    logic [7:0]  e_bresp;
    bit          drain, rdy, hs, fin;
    if (rst) begin
      checkOutput("rst_bready", s_bready, 0);
      checkOutput("rst_stall", aw_stall, 0);
      checkOutput("rst_bvalid", dsp_bvalid, 0);
      checkOutput("rst_mismatch", id_mismatch, 0);
      checkOutput("rst_bid", dsp_bid, 0);
      checkOutput("rst_bresp", dsp_bresp, 0);
      mq.delete();
      m_sub = 0; m_best = -1; m_full = 0;
      m_mst = 0; m_id = 0; m_resp = 0; m_mism = 0;
    end else begin
      for (int k = 0; k < MST_AMT; k++) begin
        e_bid[k*5 +: 5]   = 5'(m_id);
        e_bresp[k*2 +: 2] = 2'(m_resp);
      end
      drain = m_full && dsp_bready[m_mst];
      rdy   = (mq.size() > 0) && ((m_sub < mq[0].split) || !m_full || drain);
      checkOutput("m_bready", s_bready, int'(rdy));
      checkOutput("m_stall", aw_stall, int'(mq.size() == DEPTH));
      checkOutput("m_bvalid", dsp_bvalid, m_full ? (1 << m_mst) : 0);
      checkOutput("m_bid", dsp_bid, e_bid);
      checkOutput("m_bresp", dsp_bresp, e_bresp);
      checkOutput("m_mismatch", id_mismatch, int'(m_mism));
      hs  = s_bvalid && rdy;
      fin = hs && (m_sub == mq[0].split);
      if (hs && (int'(s_bid) != mq[0].id)) m_mism = 1;
      if (fin) begin
        m_resp = merge_resp(m_best, int'(s_bresp));
        m_full = 1;
        m_mst  = int'(s_bid[6:5]);
        m_id   = int'(s_bid[4:0]);
        void'(mq.pop_front());
        m_sub  = 0;
        m_best = -1;
      end else begin
        if (hs) begin
          m_sub++;
          m_best = merge_resp(m_best, int'(s_bresp));
        end
        if (drain) m_full = 0;
      end
      if (aw_shift && (mq.size() < DEPTH)) mq.push_back('{int'(aw_split), int'(aw_id)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_aw(int id, int split);
    aw_id    = 7'(id);
    aw_split = 3'(split);
    aw_shift = 1'b1;
    tick();
    aw_shift = 1'b0;
  endtask

  task automatic slave_b(int id, int resp);
    bit done;
    int n;
    done = 0;
    n = 0;
    s_bid    = 7'(id);
    s_bresp  = 2'(resp);
    s_bvalid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      done = s_bready;
      tick();
      n++;
    end
    s_bvalid = 1'b0;
    checkOutput("slave_handshake", int'(done), 1);
  endtask

  task automatic applyStimulus(int cycles);
    for (int c = 0; c < cycles; c++) begin
      aw_shift   = ($urandom % 3) == 0;
      aw_id      = 7'($urandom % 128);
      aw_split   = (($urandom % 4) == 0) ? 3'($urandom % 8) : 3'd0;
      s_bvalid   = ($urandom % 2) == 1;
      s_bresp    = 2'($urandom % 4);
      if (mq.size() > 0 && ($urandom % 32) != 0) s_bid = 7'(mq[0].id);
      else                                       s_bid = 7'($urandom % 128);
      dsp_bready = 4'($urandom % 16);
      rst        = ($urandom % 700) == 0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; aw_id = '0; aw_split = '0; aw_shift = 1'b0;
    s_bid = '0; s_bresp = '0; s_bvalid = 1'b0; dsp_bready = 4'hF;
    repeat (3) tick();
    checkOutput("reset_bvalid", dsp_bvalid, 0);
    checkOutput("reset_bready", s_bready, 0);
    rst = 1'b0;
    tick();

    // Unsplit: 0x41 -> master 2, local ID 1, OKAY, one cycle after handshake.
    push_aw(7'h41, 0);
    slave_b(7'h41, 0);
    checkOutput("unsplit_valid", dsp_bvalid, 4'b0100);
    checkOutput("unsplit_bid", dsp_bid[4:0], 1);
    checkOutput("unsplit_bresp", dsp_bresp[1:0], 0);
    tick();

    // Split into three: OKAY, SLVERR, EXOKAY merge to SLVERR.
    push_aw(7'h22, 2);
    slave_b(7'h22, 0);
    checkOutput("split_absorb0", dsp_bvalid, 0);
    slave_b(7'h22, 2);
    checkOutput("split_absorb1", dsp_bvalid, 0);
    slave_b(7'h22, 1);
    checkOutput("split_valid", dsp_bvalid, 4'b0010);
    checkOutput("split_bresp", dsp_bresp[1:0], 2);
    checkOutput("split_bid", dsp_bid[4:0], 2);
    tick();

    // Backpressure on the output register.
    dsp_bready = 4'h0;
    push_aw(7'h10, 0);
    push_aw(7'h11, 1);
    slave_b(7'h10, 3);
    checkOutput("bp_first_valid", dsp_bvalid, 4'b0001);
    s_bid = 7'h11; s_bresp = 2'd0; s_bvalid = 1'b1;
    @(negedge clk);
    checkOutput("bp_nonfinal_ready", s_bready, 1);
    tick();
    s_bresp = 2'd2;
    @(negedge clk);
    checkOutput("bp_final_blocked0", s_bready, 0);
    tick();
    @(negedge clk);
    checkOutput("bp_final_blocked1", s_bready, 0);
    tick();
    dsp_bready = 4'b0001;
    @(negedge clk);
    checkOutput("bp_final_drain_ready", s_bready, 1);
    tick();
    s_bvalid = 1'b0;
    dsp_bready = 4'hF;
    checkOutput("bp_second_valid", dsp_bvalid, 4'b0001);
    checkOutput("bp_second_bid", dsp_bid[4:0], 5'h11);
    checkOutput("bp_second_bresp", dsp_bresp[1:0], 2);
    tick();

    // Fill to capacity, drop a ninth push, then push+pop at full.
    for (int i = 0; i < 8; i++) push_aw(i, 0);
    checkOutput("full_stall", aw_stall, 1);
    push_aw(8, 0);
    checkOutput("full_drop_stall", aw_stall, 1);
    aw_id = 7'd9; aw_split = 3'd0; aw_shift = 1'b1;
    s_bid = 7'd0; s_bresp = 2'd0; s_bvalid = 1'b1;
    @(negedge clk);
    checkOutput("full_pushpop_ready", s_bready, 1);
    tick();
    aw_shift = 1'b0; s_bvalid = 1'b0;
    checkOutput("full_pushpop_stall", aw_stall, 1);
    for (int i = 1; i < 8; i++) slave_b(i, 0);
    slave_b(9, 0);
    s_bvalid = 1'b1;
    @(negedge clk);
    checkOutput("empty_no_ready", s_bready, 0);
    tick();
    s_bvalid = 1'b0;
    checkOutput("empty_stall", aw_stall, 0);

    // ID mismatch is sticky until reset.
    push_aw(7'h05, 0);
    slave_b(7'h06, 0);
    checkOutput("mismatch_set", id_mismatch, 1);
    repeat (3) tick();
    checkOutput("mismatch_hold", id_mismatch, 1);
    rst = 1'b1;
    repeat (2) tick();
    checkOutput("mismatch_clear", id_mismatch, 0);
    rst = 1'b0;
    tick();

    // Reset mid-merge discards the DECERR already absorbed.
    push_aw(7'h30, 2);
    slave_b(7'h30, 3);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    push_aw(7'h31, 0);
    slave_b(7'h31, 0);
    checkOutput("midreset_valid", dsp_bvalid, 4'b0010);
    checkOutput("midreset_bresp", dsp_bresp[1:0], 0);
    tick();

    applyStimulus(4000);

    rst = 1'b0; aw_shift = 1'b0; s_bvalid = 1'b0;
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sa_wresp_merge.md
SA_WRESP_MERGE -- requirements
Module: sa_wresp_merge

Interface
REQ-001 Parameter MST_AMT, default 4: number of masters served.
REQ-002 Parameter OUTSTANDING_AMT, default 8: depth of the AW tracking FIFO (power of two).
REQ-003 Parameter MST_ID_W, default $clog2(MST_AMT): width of the master index.
REQ-004 Parameter TRANS_MST_ID_W, default 5: width of the master-side transaction ID.
REQ-005 Parameter TRANS_SLV_ID_W, default TRANS_MST_ID_W+MST_ID_W: width of the slave-side ID; the master index occupies the MSBs.
REQ-006 Parameter TRANS_WR_RESP_W, default 2: BRESP width.
REQ-007 Parameter SPLIT_W, default 3: width of the split count; maximum of 2^SPLIT_W sub-transactions per AW.
REQ-008 ACLK_i  in  1  clock; all logic is on the rising edge.
REQ-009 ARESET_i  in  1  reset; synchronous and active-high.
REQ-010 AW_AxID_i  in  TRANS_SLV_ID_W  ID of the issued write.
REQ-011 AW_split_num_i  in  SPLIT_W  number of sub-responses minus 1 (0 = unsplit).
REQ-012 AW_shift_en_i  in  1  push strobe for the AW tracking entry.
REQ-013 AW_stall_o  out  1  tracking FIFO full.
REQ-014 s_BID_i / s_BRESP_i / s_BVALID_i  in  TRANS_SLV_ID_W / TRANS_WR_RESP_W / 1  slave B channel.
REQ-015 s_BREADY_o  out  1  slave B ready.
REQ-016 dsp_BID_o / dsp_BRESP_o / dsp_BVALID_o  out  TRANS_MST_ID_W*MST_AMT / TRANS_WR_RESP_W*MST_AMT / MST_AMT  per-master B outputs.
REQ-017 dsp_BREADY_i  in  MST_AMT  per-master B ready.
REQ-018 id_mismatch_o  out  1  sticky protocol-error flag.

Function
REQ-019 The tracking FIFO shall store {split_num, AxID}; an entry is pushed when AW_shift_en_i=1 and the FIFO is not full; a push while full shall be dropped.
REQ-020 AW_stall_o shall equal FIFO full; a pushed entry shall become visible at the head no earlier than the next cycle (no bypass).
REQ-021 Slave responses arrive in AW issue order; each slave handshake (s_BVALID_i & s_BREADY_o) consumes one sub-response of the head entry.
REQ-022 The sub-response counter sub_cnt (SPLIT_W bits) shall start at 0; a handshake with sub_cnt<split_num shall increment it and update the accumulator; a handshake with sub_cnt==split_num (the final handshake) shall pop the FIFO and clear sub_cnt to 0.
REQ-023 The accumulator shall merge BRESP by priority DECERR(3) > SLVERR(2) > OKAY(0) > EXOKAY(1); the merged value is the highest-priority code over all sub-responses including the final one; the accumulator shall clear on the final handshake.
REQ-024 The output register has states EMPTY and FULL; the final handshake loads {mst_id = s_BID_i MSBs, s_BID_i[TRANS_MST_ID_W-1:0], merged BRESP} and enters FULL.
REQ-025 In FULL, dsp_BVALID_o[mst_id] shall be 1 and all other bits 0; the state shall return to EMPTY on dsp_BREADY_i[mst_id]=1 unless it is reloaded in the same cycle.
REQ-026 dsp_BID_o and dsp_BRESP_o shall broadcast the registered ID and response to every master slice.
REQ-027 s_BREADY_o shall be 1 only when the FIFO is not empty and either (a) sub_cnt<split_num, or (b) the output register is EMPTY or is draining this cycle.
REQ-028 The latency from the final slave handshake at cycle N to dsp_BVALID_o shall be cycle N+1.
REQ-029 Non-final sub-responses shall be absorbed and shall never assert dsp_BVALID_o.
REQ-030 If a slave handshake occurs with s_BID_i different from the head AxID, the handshake shall still be consumed, and id_mismatch_o shall be set and held until reset.
REQ-031 If the FIFO is empty, s_BREADY_o shall be 0 regardless of s_BVALID_i.
REQ-032 A push and a final pop in the same cycle shall both take effect, leaving the occupancy unchanged.

Reset
REQ-033 While ARESET_i=1 the FIFO shall be emptied, sub_cnt and the accumulator cleared, and the output register set to EMPTY.
REQ-034 While ARESET_i=1 the outputs shall be dsp_BVALID_o=0, s_BREADY_o=0, AW_stall_o=0 and id_mismatch_o=0, and dsp_BID_o and dsp_BRESP_o shall be 0.
REQ-035 An assertion of reset mid-merge shall discard the partial accumulation and all pending entries.

Verification
REQ-036 Unsplit case: push ID=0x41 with split=0, then slave B (ID 0x41, OKAY) -> dsp_BVALID_o=4'b0100 one cycle later with BID=1 and BRESP=OKAY.
REQ-037 Split case: push split=2; slave sub-responses OKAY, SLVERR, EXOKAY -> a single dsp response with BRESP=SLVERR; no dsp valid on the first two sub-responses.
REQ-038 Backpressure: with dsp_BREADY_i=0 and the output FULL, a final slave B is offered -> s_BREADY_o=0 until the master accepts; a non-final sub-response is still accepted.
REQ-039 Full case: 8 pushes without responses -> AW_stall_o=1 and a 9th push is dropped; a simultaneous push and final pop at full keep the count at 8.
REQ-040 Mismatch case: head ID 0x05 and slave BID 0x06 -> the response is consumed and id_mismatch_o=1 and stays 1; reset clears it.
REQ-041 Mid-merge reset: reset asserted after 1 of 3 sub-responses -> after reset, an unsplit transaction merges cleanly with no stale accumulated BRESP.
